iagc_cmd_decoder: RTL

// - Receives UART RX bytes and decodes framed host commands.
// - Presents each command as {operation, parameter} with a valid flag to the IAGC control FSM.
// - Holds o_cmd_valid until the FSM reports status CMD_PARSE, then releases it.
// - Sits between the UART receiver and the IAGC FSM; counts framing errors and overruns.

---
 rtl/iagc_cmd_if.sv | 38 +++
 rtl/iagc_cmd_decoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/iagc_cmd_if.sv
// iagc_cmd_if
// Bundles the byte stream from the UART receiver, the IAGC FSM status, and
// the decoded-command outputs of iagc_cmd_decoder.
//   i_rx_data / i_rx_valid : received byte and its one-cycle strobe
//   i_status               : current IAGC FSM state code
//   o_cmd_valid            : a decoded command is pending
//   o_cmd_operation        : opcode of the last accepted command
//   o_cmd_parameter        : parameter of the last accepted command
//   o_frame_err            : one-cycle pulse, bad checksum or inter-byte timeout
//   o_overrun              : one-cycle pulse, good frame dropped while one was pending
//   o_err_count            : saturating count of frame_err plus overrun events
// Modports: slave = decoder side, master = driver of bytes/status.
interface iagc_cmd_if #(
    parameter int STATUS_SIZE    = 4,
    parameter int CMD_PARAM_SIZE = 4
);
    logic [7:0]                i_rx_data;
    logic                      i_rx_valid;
    logic [STATUS_SIZE-1:0]    i_status;
    logic                      o_cmd_valid;
    logic [CMD_PARAM_SIZE-1:0] o_cmd_operation;
    logic [CMD_PARAM_SIZE-1:0] o_cmd_parameter;
    logic                      o_frame_err;
    logic                      o_overrun;
    logic [7:0]                o_err_count;

    modport slave (
        input  i_rx_data, i_rx_valid, i_status,
        output o_cmd_valid, o_cmd_operation, o_cmd_parameter,
               o_frame_err, o_overrun, o_err_count
    );

    modport master (
        output i_rx_data, i_rx_valid, i_status,
        input  o_cmd_valid, o_cmd_operation, o_cmd_parameter,
               o_frame_err, o_overrun, o_err_count
    );
endinterface

// File: rtl/iagc_cmd_decoder.sv
// iagc_cmd_decoder
// Decodes three-byte host frames {SYNC_BYTE, CMD, ~CMD} from the UART receiver
// and presents {operation, parameter} plus a valid flag to the IAGC control FSM.
// The valid flag is held until the FSM reports STATUS_CMD_PARSE.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : iagc_cmd_if.slave (byte stream in, status in, command/error out)
module iagc_cmd_decoder #(
    parameter int                     STATUS_SIZE      = 4,
    parameter int                     CMD_PARAM_SIZE   = 4,
    parameter logic [7:0]             SYNC_BYTE        = 8'hA5,
    parameter logic [STATUS_SIZE-1:0] STATUS_CMD_PARSE = 4'b0100,
    parameter int                     TIMEOUT_CYCLES   = 100000,
    parameter int                     TIMEOUT_W        = 17
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    iagc_cmd_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        WAIT_CMD  = 2'd1,
        WAIT_CHK  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                    state_q, state_d;
    logic [TIMEOUT_W-1:0]      tmo_q, tmo_d;
    logic [7:0]                cmd_shadow_p0;
    logic                      vld_p1, vld_d;
    logic [CMD_PARAM_SIZE-1:0] cmd_op_p1;
    logic [CMD_PARAM_SIZE-1:0] cmd_param_p1;
    logic                      frame_err_p1, frame_err_d;
    logic                      overrun_p1, overrun_d;
    logic [7:0]                err_cnt_p1;
    logic                      accept, take, release_cmd;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        accept      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_SYNC: begin
                tmo_d = '0;
                if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE)
                    state_d = WAIT_CMD;
            end
            WAIT_CMD, WAIT_CHK: begin
                // An arriving byte always wins over a coincident timeout.
                if (bus.i_rx_valid) begin
                    tmo_d = '0;
                    if (state_q == WAIT_CMD) begin
                        state_d = WAIT_CHK;
                    end else begin
                        state_d = WAIT_SYNC;
                        if (bus.i_rx_data == ~cmd_shadow_p0)
                            accept = 1'b1;
                        else
                            frame_err_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    state_d     = WAIT_SYNC;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_SYNC;
                tmo_d   = '0;
            end
        endcase

        // Release is evaluated before accept, so a frame completing on the
        // acknowledge cycle replaces the pending command instead of overrunning.
        release_cmd = vld_p1 && (bus.i_status == STATUS_CMD_PARSE);
        overrun_d   = accept && vld_p1 && !release_cmd;
        take        = accept && !overrun_d;
        vld_d       = take || (vld_p1 && !release_cmd);
    end

    // Stage p0: CMD byte shadow (data only, no reset needed)
    always_ff @(posedge i_clock) begin
        if (bus.i_rx_valid && state_q == WAIT_CMD)
            cmd_shadow_p0 <= bus.i_rx_data;
    end

    // Stage p1: parser state, registered command and error outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= WAIT_SYNC;
            tmo_q        <= '0;
            vld_p1       <= 1'b0;
            cmd_op_p1    <= '0;
            cmd_param_p1 <= '0;
            frame_err_p1 <= 1'b0;
            overrun_p1   <= 1'b0;
            err_cnt_p1   <= 8'h00;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            vld_p1       <= vld_d;
            frame_err_p1 <= frame_err_d;
            overrun_p1   <= overrun_d;
            if (take) begin
                cmd_op_p1    <= cmd_shadow_p0[7:4];
                cmd_param_p1 <= cmd_shadow_p0[3:0];
            end
            // frame_err and overrun are mutually exclusive, so one step suffices.
            if (frame_err_d || overrun_d)
                err_cnt_p1 <= sat_inc(err_cnt_p1);
        end
    end

    assign bus.o_cmd_valid     = vld_p1;
    assign bus.o_cmd_operation = cmd_op_p1;
    assign bus.o_cmd_parameter = cmd_param_p1;
    assign bus.o_frame_err     = frame_err_p1;
    assign bus.o_overrun       = overrun_p1;
    assign bus.o_err_count     = err_cnt_p1;

endmodule
